// File: rtl/dvp_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// dvp_pattern_tx_if
// Parallel DVP camera bus (OV5640 style). The pixel clock is the system clock
// of the transmitter and is not carried here.
//
// Signals:
//   cam_vsync  frame sync, active high
//   cam_href   line valid, high during active bytes
//   cam_data   8-bit pixel byte (RGB565, high byte first)
//
// Modports:
//   master  transmitter side (drives the bus)
//   slave   capture side (samples the bus)
// -----------------------------------------------------------------------------
interface dvp_pattern_tx_if;

    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    modport master (
        output cam_vsync,
        output cam_href,
        output cam_data
    );

    modport slave (
        input cam_vsync,
        input cam_href,
        input cam_data
    );

endinterface : dvp_pattern_tx_if

// File: rtl/dvp_pattern_tx.sv
// -----------------------------------------------------------------------------
// dvp_pattern_tx
// DVP camera-output emulator. Generates vsync/href/data for RGB565 test
// frames (colour bars, ramp, checkerboard, solid), one byte per clk, so a
// capture path can be exercised without a physical sensor.
//
// Parameters:
//   VS_LINES   lines with vsync high at frame start
//   VBP_LINES  blank lines between vsync and the first active line
//   BAR_W      colour-bar width in pixels
//
// Ports:
//   clk              byte clock, also the DVP pixel clock
//   rst              synchronous active-high reset
//   i_enable         start / continue frame generation
//   i_pattern_sel    0 bars, 1 ramp, 2 checkerboard, 3 solid
//   i_solid_rgb      pixel value for the solid pattern (used live)
//   i_cmos_h_pixel   active pixels per line
//   i_cmos_v_pixel   active lines per frame
//   i_total_h_pixel  total pixels per line including blanking
//   i_total_v_pixel  total lines per frame
//   dvp              DVP bus (master modport): cam_vsync, cam_href, cam_data
//   o_busy           high while a frame is in progress
//   o_cfg_err        the last start attempt was rejected
//   o_frame_cnt      completed frames, wrapping
//
// Build option:
//   DVP_TX_SCROLL_EN  when defined, patterns 0-2 scroll by one pixel per frame.
// -----------------------------------------------------------------------------
module dvp_pattern_tx #(
    parameter int unsigned VS_LINES  = 2,
    parameter int unsigned VBP_LINES = 4,
    parameter int unsigned BAR_W     = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [1:0]       i_pattern_sel,
    input  logic [15:0]      i_solid_rgb,
    input  logic [12:0]      i_cmos_h_pixel,
    input  logic [12:0]      i_cmos_v_pixel,
    input  logic [12:0]      i_total_h_pixel,
    input  logic [12:0]      i_total_v_pixel,
    dvp_pattern_tx_if.master dvp,
    output logic             o_busy,
    output logic             o_cfg_err,
    output logic [15:0]      o_frame_cnt
);

    localparam int unsigned SW   = 13;
    localparam int unsigned CW   = 14;
    localparam int unsigned FW   = 16;
    localparam int unsigned BPW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned ACT0 = VS_LINES + VBP_LINES;

    localparam logic [CW-1:0]  C_ACT0     = CW'(ACT0);
    localparam logic [CW-1:0]  C_VS       = CW'(VS_LINES);
    localparam logic [CW-1:0]  C_BIT4     = CW'(16);
    localparam logic [BPW-1:0] C_BAR_LAST = BPW'(BAR_W - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_start;
    logic           w_reject;

    // Frame configuration latched at each frame start
    logic [SW-1:0]  r_h_pix;
    logic [SW-1:0]  r_v_pix;
    logic [SW-1:0]  r_tot_h;
    logic [SW-1:0]  r_tot_v;
    logic [1:0]     r_pat;

    logic [CW-1:0]  r_bcnt;
    logic [CW-1:0]  r_lcnt;
    logic [BPW-1:0] r_bar_px;
    logic [2:0]     r_bar_idx;
    logic [FW-1:0]  r_frame_cnt;

    logic           r_vsync;
    logic           r_href;
    logic [7:0]     r_data;
    logic           r_busy;
    logic           r_cfg_err;

    logic           w_cfg_ok;
    logic [CW-1:0]  w_bmax;
    logic           w_line_end;
    logic           w_frame_end;
    logic           w_active_line;
    logic           w_href;
    logic           w_vsync;
    logic [5:0]     w_x;          // pattern x coordinate, bits [7:2]
    logic           w_y4;         // pattern y coordinate, bit 4
    logic [15:0]    w_bar_rgb;
    logic [15:0]    w_pixel;
    logic [BPW-1:0] w_bar_px_adv;
    logic [2:0]     w_bar_idx_adv;
    logic [BPW-1:0] w_ph_px;      // bar phase at line start
    logic [2:0]     w_ph_idx;
    logic [BPW-1:0] w_ph_nxt_px;  // bar phase for the following frame
    logic [2:0]     w_ph_nxt_idx;

    // Legality of the live configuration inputs
    assign w_cfg_ok = (i_cmos_h_pixel != '0) &&
                      (i_cmos_v_pixel != '0) &&
                      (i_cmos_h_pixel < i_total_h_pixel) &&
                      ((C_ACT0 + {1'b0, i_cmos_v_pixel}) <= {1'b0, i_total_v_pixel});

    // Line / frame boundaries of the latched geometry
    assign w_bmax      = {r_tot_h, 1'b0} - CW'(1);
    assign w_line_end  = (r_bcnt == w_bmax);
    assign w_frame_end = w_line_end && (r_lcnt == ({1'b0, r_tot_v} - CW'(1)));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, start and reject strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    if (w_cfg_ok) begin
                        w_state_nxt = S_FRAME;
                        w_start     = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (w_frame_end) begin
                    if (i_enable && w_cfg_ok) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_reject    = i_enable;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bar counter step to the next pixel
    always_comb begin
        w_bar_px_adv  = r_bar_px + 1'b1;
        w_bar_idx_adv = r_bar_idx;
        if (r_bar_px == C_BAR_LAST) begin
            w_bar_px_adv  = '0;
            w_bar_idx_adv = r_bar_idx + 3'd1;
        end
    end

`ifdef DVP_TX_SCROLL_EN
    logic [BPW-1:0] r_ph_px;
    logic [2:0]     r_ph_idx;

    // Bar phase tracks frame_cnt mod (8*BAR_W) incrementally, no divider
    always_comb begin
        w_ph_nxt_px  = r_ph_px + 1'b1;
        w_ph_nxt_idx = r_ph_idx;
        if (r_ph_px == C_BAR_LAST) begin
            w_ph_nxt_px  = '0;
            w_ph_nxt_idx = r_ph_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph_px  <= '0;
            r_ph_idx <= '0;
        end else if ((r_state == S_FRAME) && w_frame_end) begin
            r_ph_px  <= w_ph_nxt_px;
            r_ph_idx <= w_ph_nxt_idx;
        end
    end

    assign w_ph_px  = r_ph_px;
    assign w_ph_idx = r_ph_idx;
    // x' = x + frame_cnt[7:0]; only bits [7:2] feed the patterns
    assign w_x      = 6'((r_bcnt[8:1] + r_frame_cnt[7:0]) >> 2);
`else
    assign w_ph_px      = '0;
    assign w_ph_idx     = '0;
    assign w_ph_nxt_px  = '0;
    assign w_ph_nxt_idx = '0;
    assign w_x          = r_bcnt[8:3];
`endif

    assign w_y4 = |((r_lcnt - C_ACT0) & C_BIT4);

    // Frame timing
    assign w_active_line = (r_lcnt >= C_ACT0) && (r_lcnt < (C_ACT0 + {1'b0, r_v_pix}));
    assign w_href        = (r_state == S_FRAME) && w_active_line && (r_bcnt < {r_h_pix, 1'b0});
    assign w_vsync       = (r_state == S_FRAME) && (r_lcnt < C_VS);

    // Colour-bar palette
    always_comb begin
        w_bar_rgb = 16'h0000;
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 16'hFFFF;
            3'd1:    w_bar_rgb = 16'hFFE0;
            3'd2:    w_bar_rgb = 16'h07FF;
            3'd3:    w_bar_rgb = 16'h07E0;
            3'd4:    w_bar_rgb = 16'hF81F;
            3'd5:    w_bar_rgb = 16'hF800;
            3'd6:    w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    // Pattern generator
    always_comb begin
        w_pixel = 16'h0000;
        case (r_pat)
            2'd0:    w_pixel = w_bar_rgb;
            2'd1:    w_pixel = {w_x[5:1], w_x[5:0], w_x[5:1]};
            2'd2:    w_pixel = (w_x[2] ^ w_y4) ? 16'hFFFF : 16'h0000;
            default: w_pixel = i_solid_rgb;
        endcase
    end

    // Configuration latch, counters, frame count and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_pix     <= '0;
            r_v_pix     <= '0;
            r_tot_h     <= '0;
            r_tot_v     <= '0;
            r_pat       <= '0;
            r_bcnt      <= '0;
            r_lcnt      <= '0;
            r_bar_px    <= '0;
            r_bar_idx   <= '0;
            r_frame_cnt <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_h_pix <= i_cmos_h_pixel;
                r_v_pix <= i_cmos_v_pixel;
                r_tot_h <= i_total_h_pixel;
                r_tot_v <= i_total_v_pixel;
                r_pat   <= i_pattern_sel;
            end

            if (w_start) begin
                r_cfg_err <= 1'b0;
            end else if (w_reject) begin
                r_cfg_err <= 1'b1;
            end

            if (r_state == S_FRAME) begin
                if (w_line_end) begin
                    r_bcnt <= '0;
                    r_lcnt <= w_frame_end ? '0 : (r_lcnt + CW'(1));
                    // Bars restart at each line; a new frame takes the next phase
                    r_bar_px  <= w_frame_end ? w_ph_nxt_px  : w_ph_px;
                    r_bar_idx <= w_frame_end ? w_ph_nxt_idx : w_ph_idx;
                end else begin
                    r_bcnt <= r_bcnt + CW'(1);
                    if (r_bcnt[0]) begin
                        r_bar_px  <= w_bar_px_adv;
                        r_bar_idx <= w_bar_idx_adv;
                    end
                end
                if (w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + FW'(1);
                end
            end else begin
                r_bar_px  <= w_ph_px;
                r_bar_idx <= w_ph_idx;
            end
        end
    end

    // Registered DVP outputs; all three change on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_data  <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            r_vsync <= w_vsync;
            r_href  <= w_href;
            r_data  <= w_href ? (r_bcnt[0] ? w_pixel[7:0] : w_pixel[15:8]) : 8'h00;
            r_busy  <= (r_state == S_FRAME);
        end
    end

    assign dvp.cam_vsync = r_vsync;
    assign dvp.cam_href  = r_href;
    assign dvp.cam_data  = r_data;
    assign o_busy        = r_busy;
    assign o_cfg_err     = r_cfg_err;
    assign o_frame_cnt   = r_frame_cnt;

endmodule : dvp_pattern_tx
